// File: rtl/video_pkg.sv
// Shared video types and helpers: framebuffer geometry derivation and
// RGB565 -> RGB888 colour expansion (also used by the debug overlay).
package video_pkg;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Framebuffer width for a given raster width and downscale shift.
    function automatic int fb_w(input int active_h_pixels, input int scale_shift);
        return active_h_pixels >> scale_shift;
    endfunction

    // Framebuffer height for a given raster height and downscale shift.
    function automatic int fb_h(input int active_lines, input int scale_shift);
        return active_lines >> scale_shift;
    endfunction

    // Replicate the top bits into the new LSBs so full-scale stays full-scale.
    function automatic rgb888_t rgb565_to_888(input rgb565_t c);
        rgb888_t o;
        o.r = {c.r, c.r[4:2]};
        o.g = {c.g, c.g[5:4]};
        o.b = {c.b, c.b[4:2]};
        return o;
    endfunction

endpackage

// File: rtl/strobe_delay.sv
// Generic synchronous-reset shift register used to re-align strobes with
// the BRAM read pipeline.
module strobe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_pixel_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] strobe,
    output logic [WIDTH-1:0] strobe_delayed
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per pixel clock; reset flushes everything in flight.
    always_ff @(posedge clk_pixel_in) begin
        // NOTE: this array is a handful of flops, not a RAM, so resetting it is
        // cheap and guarantees no stale strobes leak out after a mid-frame reset.
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage capture the
            // previous stage's old value, which is what a shift register needs.
            stage[0] <= strobe;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign strobe_delayed = stage[DEPTH-1];

endmodule

// File: rtl/frame_buffer_reader.sv
// Converts raster position into double-buffered framebuffer read addresses,
// expands returned RGB565 to RGB888 and keeps hs/vs/ad aligned to pixels.
// Front/back buffer swaps happen only on a new-frame pulse.
module frame_buffer_reader
    import video_pkg::*;
#(
    parameter int ACTIVE_H_PIXELS = 1280,
    parameter int ACTIVE_LINES    = 720,
    parameter int SCALE_SHIFT     = 2,
    parameter int BRAM_LATENCY    = 2
) (
    input  logic        clk_pixel_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        ad_in,
    input  logic        nf_in,
    input  logic        swap_req_in,
    output logic        swap_ack_out,
    output logic        front_buf_out,
    output logic [$clog2(2*fb_w(ACTIVE_H_PIXELS, SCALE_SHIFT)*fb_h(ACTIVE_LINES, SCALE_SHIFT))-1:0] addr_out,
    output logic        rd_en_out,
    input  logic [15:0] data_in,
    output logic [23:0] pixel_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        ad_out
);

    localparam int FB_W    = fb_w(ACTIVE_H_PIXELS, SCALE_SHIFT);
    localparam int FB_H    = fb_h(ACTIVE_LINES, SCALE_SHIFT);
    localparam int FB_SIZE = FB_W * FB_H;
    localparam int ADDR_W  = $clog2(2 * FB_SIZE);
    localparam int LATENCY = BRAM_LATENCY + 2;

    logic              front_buf;
    logic [ADDR_W-1:0] addr_next;
    logic              rd_valid;

    // Buffer base plus row/column offset; all multiplies are by constants.
    assign addr_next = (front_buf ? ADDR_W'(FB_SIZE) : '0)
                     + ADDR_W'(vcount_in >> SCALE_SHIFT) * ADDR_W'(FB_W)
                     + ADDR_W'(hcount_in >> SCALE_SHIFT);

    // Swap front/back only on a new-frame pulse so the display never tears.
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            front_buf    <= 1'b0;
            swap_ack_out <= 1'b0;
        end else begin
            swap_ack_out <= nf_in && swap_req_in;
            if (nf_in && swap_req_in) front_buf <= ~front_buf;
        end
    end

    assign front_buf_out = front_buf;

    // Address stage: issue one read per active pixel, hold address in blanking.
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            rd_en_out <= 1'b0;
            addr_out  <= '0;
        end else begin
            rd_en_out <= ad_in;
            // NOTE: a missing else inside a clocked block is just a flop enable;
            // the same omission in combinational logic would infer a latch.
            if (ad_in) addr_out <= addr_next;
        end
    end

    // Read-enable delayed by the BRAM latency marks cycles where data_in is real.
    strobe_delay #(
        .WIDTH(1),
        .DEPTH(BRAM_LATENCY)
    ) u_valid_delay (
        .clk_pixel_in   (clk_pixel_in),
        .rst_in         (rst_in),
        .strobe         (rd_en_out),
        .strobe_delayed (rd_valid)
    );

    // Data stage: expand returned colour, force black whenever not drawing.
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            pixel_out <= '0;
        end else if (rd_valid) begin
            pixel_out <= rgb565_to_888(data_in);
        end else begin
            pixel_out <= '0;
        end
    end

    // Sync and active-draw strobes travel the full pipeline depth.
    strobe_delay #(
        .WIDTH(3),
        .DEPTH(LATENCY)
    ) u_strobe_delay (
        .clk_pixel_in   (clk_pixel_in),
        .rst_in         (rst_in),
        .strobe         ({hs_in, vs_in, ad_in}),
        .strobe_delayed ({hs_out, vs_out, ad_out})
    );

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Self-checking bench for frame_buffer_reader: directed raster segments,
// a BRAM model, a cycle-level reference model and literal spot checks.
module tb_frame_buffer_reader;

    localparam int L     = 4;
    localparam int FB_W  = 1280 / 4;
    localparam int FB_H  = 720 / 4;
    localparam int AW    = 17;

    logic          clk_pixel_in = 1'b0;
    logic          rst_in;
    logic [10:0]   hcount_in;
    logic [9:0]    vcount_in;
    logic          hs_in, vs_in, ad_in, nf_in, swap_req_in;
    logic          swap_ack_out, front_buf_out, rd_en_out;
    logic [AW-1:0] addr_out;
    logic [15:0]   data_in;
    logic [23:0]   pixel_out;
    logic          hs_out, vs_out, ad_out;

    always #5 clk_pixel_in = ~clk_pixel_in;

    frame_buffer_reader dut (
        .clk_pixel_in  (clk_pixel_in),
        .rst_in        (rst_in),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .hs_in         (hs_in),
        .vs_in         (vs_in),
        .ad_in         (ad_in),
        .nf_in         (nf_in),
        .swap_req_in   (swap_req_in),
        .swap_ack_out  (swap_ack_out),
        .front_buf_out (front_buf_out),
        .addr_out      (addr_out),
        .rd_en_out     (rd_en_out),
        .data_in       (data_in),
        .pixel_out     (pixel_out),
        .hs_out        (hs_out),
        .vs_out        (vs_out),
        .ad_out        (ad_out)
    );

    int checks = 0;
    int errors = 0;
    int mode   = 0;   // BRAM content: 0 = addr[15:0], 1 = F800, 2 = 07E0

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_val(input int m, input logic [AW-1:0] a);
        case (m)
            1:       return 16'hF800;
            2:       return 16'h07E0;
            default: return a[15:0];
        endcase
    endfunction

    function automatic logic [23:0] exp888(input logic [15:0] d);
        int r5, g6, b5, r8, g8, b8;
        r5 = (int'(d) >> 11) & 31;
        g6 = (int'(d) >> 5) & 63;
        b5 = int'(d) & 31;
        r8 = (r5 << 3) | (r5 >> 2);
        g8 = (g6 << 2) | (g6 >> 4);
        b8 = (b5 << 3) | (b5 >> 2);
        return 24'((r8 << 16) | (g8 << 8) | b8);
    endfunction

    // BRAM model: two-cycle read latency, content selected by mode.
    logic [15:0] bram_p1;
    always @(posedge clk_pixel_in) begin
        bram_p1 <= mem_val(mode, addr_out);
        data_in <= bram_p1;
    end

    // Reference model: per-cycle input history plus displayed-buffer state.
    typedef struct {
        logic        rst, ad, hs, vs, nf, req, fb;
        logic [10:0] hc;
        logic [9:0]  vc;
        int          mode;
    } rec_t;

    rec_t          hist[$];
    logic          fb_model   = 1'b0;
    logic [AW-1:0] addr_model = '0;
    bit            started    = 0;

    function automatic int addr_of(input rec_t r);
        int a;
        a = (r.fb ? FB_W * FB_H : 0) + (int'(r.vc) / 4) * FB_W + int'(r.hc) / 4;
        return a % (1 << AW);
    endfunction

    always @(posedge clk_pixel_in) begin
        rec_t r;
        r.rst = rst_in; r.ad = ad_in; r.hs = hs_in; r.vs = vs_in;
        r.nf = nf_in; r.req = swap_req_in; r.fb = fb_model;
        r.hc = hcount_in; r.vc = vcount_in; r.mode = mode;
        hist.push_front(r);
        if (hist.size() > L) void'(hist.pop_back());
        if (rst_in) begin
            fb_model   = 1'b0;
            addr_model = '0;
        end else begin
            if (ad_in) addr_model = AW'(addr_of(r));
            if (nf_in && swap_req_in) fb_model = ~fb_model;
        end
        started = 1;
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk_pixel_in) begin
        rec_t o, n;
        bit any_rst;
        logic [23:0] exp_pix;
        if (started) begin
            any_rst = 0;
            for (int i = 0; i < L; i++) if (hist[i].rst) any_rst = 1;
            o = hist[L-1];
            n = hist[0];
            exp_pix = (any_rst || !o.ad) ? 24'h0 : exp888(mem_val(o.mode, AW'(addr_of(o))));
            check("pixel_out", pixel_out, exp_pix);
            check("ad_out", ad_out, any_rst ? 1'b0 : o.ad);
            check("hs_out", hs_out, any_rst ? 1'b0 : o.hs);
            check("vs_out", vs_out, any_rst ? 1'b0 : o.vs);
            check("rd_en_out", rd_en_out, !n.rst && n.ad);
            check("addr_out", addr_out, addr_model);
            check("front_buf_out", front_buf_out, fb_model);
            check("swap_ack_out", swap_ack_out, !n.rst && n.nf && n.req);
        end
    end

    // One pixel clock of stimulus; returns 1 time unit after the sampling edge.
    task automatic cyc(input int h, input int v, input logic a, input logic hs, input logic vs, input logic nf);
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        ad_in = a; hs_in = hs; vs_in = vs; nf_in = nf;
        @(posedge clk_pixel_in);
        #1;
    endtask

    task automatic blank(input int v);
        for (int i = 0; i < 8; i++) cyc(1280 + i, v, 1'b0, (i >= 2 && i < 5), 1'b0, 1'b0);
    endtask

    task automatic line(input int v, input int npix);
        for (int h = 0; h < npix; h++) cyc(h, v, 1'b1, 1'b0, 1'b0, 1'b0);
        blank(v);
    endtask

    // Vertical blanking with an optional new-frame pulse at index nf_at.
    task automatic vblank(input int nf_at);
        for (int i = 0; i < 6; i++) cyc(1280, 720 + i, 1'b0, 1'b0, 1'b1, (i == nf_at));
    endtask

    // Active line with one pinned pixel value, then blanking forces black.
    task automatic pix_line(input int v, input int pin_h, input logic [23:0] pin_exp, input string name);
        for (int h = 0; h < 12; h++) begin
            cyc(h, v, 1'b1, 1'b0, 1'b0, 1'b0);
            if (h == pin_h) check(name, pixel_out, pin_exp);
        end
        blank(v);
        check("blank_pixel", pixel_out, 24'h0);
        check("blank_ad", ad_out, 1'b0);
    endtask

    initial begin
        rec_t pre;
        pre.rst = 1; pre.ad = 0; pre.hs = 0; pre.vs = 0; pre.nf = 0; pre.req = 0;
        pre.fb = 0; pre.hc = '0; pre.vc = '0; pre.mode = 0;
        for (int i = 0; i < L; i++) hist.push_back(pre);

        // Reset held for 3 cycles with random inputs.
        rst_in = 1'b1;
        repeat (3) begin
            swap_req_in = 1'($urandom_range(0, 1));
            cyc($urandom_range(0, 2047), $urandom_range(0, 1023), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        check("rst_rd_en", rd_en_out, 1'b0);
        check("rst_addr", addr_out, 0);
        check("rst_pixel", pixel_out, 0);
        check("rst_strobes", {hs_out, vs_out, ad_out}, 3'b000);
        check("rst_front_buf", front_buf_out, 1'b0);
        check("rst_ack", swap_ack_out, 1'b0);
        rst_in = 1'b0;
        swap_req_in = 1'b0;
        vblank(-1);

        // Address mapping with data = addr.
        mode = 0;
        for (int v = 0; v < 5; v++) begin
            for (int h = 0; h < 12; h++) begin
                cyc(h, v, 1'b1, 1'b0, 1'b0, 1'b0);
                if (v == 0 && h < 4)  check("addr_line0_px0to3", addr_out, 0);
                if (v == 0 && h == 4) check("addr_line0_px4", addr_out, 1);
                if (v == 4 && h == 0) check("addr_line4_px0", addr_out, 320);
                if (v == 4 && h == 3) begin
                    check("lag4_pixel", pixel_out, 24'h002800);
                    check("lag4_ad", ad_out, 1'b1);
                end
            end
            blank(v);
        end
        vblank(-1);

        // Colour expansion with constant BRAM content.
        mode = 1;
        pix_line(8, 6, 24'hFF0000, "red_F800");
        mode = 2;
        pix_line(12, 6, 24'h00FF00, "green_07E0");
        mode = 0;

        // Swap request raised mid-frame at line 100.
        line(99, 12);
        for (int h = 0; h < 12; h++) begin
            if (h == 5) swap_req_in = 1'b1;
            cyc(h, 100, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        blank(100);
        check("no_ack_midframe", swap_ack_out, 1'b0);
        check("no_swap_midframe", front_buf_out, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1280, 720 + i, 1'b0, 1'b0, 1'b1, 1'b0);
        check("no_ack_before_nf", swap_ack_out, 1'b0);
        cyc(1280, 723, 1'b0, 1'b0, 1'b1, 1'b1);
        check("ack_after_nf", swap_ack_out, 1'b1);
        check("front_after_nf", front_buf_out, 1'b1);
        swap_req_in = 1'b0;
        cyc(1280, 724, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ack_one_cycle", swap_ack_out, 1'b0);
        cyc(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("addr_back_buffer", addr_out, 57600);
        for (int h = 1; h < 12; h++) cyc(h, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        blank(0);

        // Request rising in the same cycle as nf.
        cyc(1280, 720, 1'b0, 1'b0, 1'b1, 1'b0);
        swap_req_in = 1'b1;
        cyc(1280, 721, 1'b0, 1'b0, 1'b1, 1'b1);
        check("same_cycle_ack", swap_ack_out, 1'b1);
        check("same_cycle_front", front_buf_out, 1'b0);
        swap_req_in = 1'b0;
        cyc(1280, 722, 1'b0, 1'b0, 1'b1, 1'b0);

        // Request held across two frames: two toggles, back to buffer 0.
        line(0, 12);
        swap_req_in = 1'b1;
        vblank(2);
        check("held_first_toggle", front_buf_out, 1'b1);
        line(0, 12);
        vblank(2);
        check("held_second_toggle", front_buf_out, 1'b0);
        swap_req_in = 1'b0;

        // Show buffer 1, then reset mid-line at line 300, pixel 500.
        swap_req_in = 1'b1;
        vblank(2);
        swap_req_in = 1'b0;
        check("pre_reset_front", front_buf_out, 1'b1);
        for (int h = 496; h < 500; h++) cyc(h, 300, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_in = 1'b1;
        cyc(500, 300, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_in = 1'b0;
        check("midrst_pixel", pixel_out, 0);
        check("midrst_strobes", {hs_out, vs_out, ad_out}, 3'b000);
        check("midrst_rd_en", rd_en_out, 1'b0);
        check("midrst_addr", addr_out, 0);
        check("midrst_front", front_buf_out, 1'b0);
        for (int h = 501; h < 505; h++) begin
            cyc(h, 300, 1'b1, 1'b0, 1'b0, 1'b0);
            if (h == 503) check("refill_not_yet", ad_out, 1'b0);
        end
        check("refill_ad", ad_out, 1'b1);
        check("refill_pixel", pixel_out, 24'h5AC7EF);
        for (int h = 505; h < 512; h++) cyc(h, 300, 1'b1, 1'b0, 1'b0, 1'b0);
        blank(300);
        vblank(-1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_buffer_reader.md
# frame_buffer_reader

Pixel-domain stage directly downstream of `video_sig_gen`. It turns the raster position and timing strobes into read addresses for a double-buffered, integer-downscaled RGB565 framebuffer in BRAM. It expands the returned words to RGB888 and re-aligns hs/vs/ad with the pixel data so the TMDS/HDMI output stage gets a coherent stream. It also owns front/back buffer selection through a frame-boundary swap handshake with the frame writer.

## Interface
Parameters:
- `ACTIVE_H_PIXELS`, 1280, active pixels per line
- `ACTIVE_LINES`, 720, active lines per frame
- `SCALE_SHIFT`, 2, log2 of the upscale factor; framebuffer is `FB_W = ACTIVE_H_PIXELS>>SCALE_SHIFT` by `FB_H = ACTIVE_LINES>>SCALE_SHIFT` (default 320x180)
- `BRAM_LATENCY`, 2, cycles from `rd_en_out`/`addr_out` to valid `data_in`

Ports:
- `clk_pixel_in`  in  1  pixel clock
- `rst_in`  in  1  synchronous, active-high reset
- `hcount_in`  in  11  horizontal position from `video_sig_gen`
- `vcount_in`  in  10  vertical position
- `hs_in`, `vs_in`, `ad_in`  in  1 each  sync and active-draw strobes, aligned to the counts
- `nf_in`  in  1  one-cycle new-frame pulse, always inside vertical blanking
- `swap_req_in`  in  1  level; back buffer is complete and ready to display
- `swap_ack_out`  out  1  one-cycle pulse; swap performed
- `front_buf_out`  out  1  buffer currently displayed (0/1)
- `addr_out`  out  clog2(2*FB_W*FB_H)  BRAM read address
- `rd_en_out`  out  1  BRAM read enable
- `data_in`  in  16  BRAM read data, RGB565
- `pixel_out`  out  24  RGB888 {R,G,B}
- `hs_out`, `vs_out`, `ad_out`  out  1 each  strobes delayed to match `pixel_out`

## Operation
- Framebuffer coordinates: `fb_x = hcount_in>>SCALE_SHIFT`, `fb_y = vcount_in>>SCALE_SHIFT`.
- Address: `addr = front_buf*FB_W*FB_H + fb_y*FB_W + fb_x`. Constant multiplies only. The result is truncated to the `addr_out` width.
- Address stage (S0, registered): when `ad_in=1`, drive `rd_en_out=1` and `addr_out=addr`. When `ad_in=0`, drive `rd_en_out=0` and `addr_out` holds its last value.
- Data stage: after `BRAM_LATENCY`, register the expansion of `data_in`:
  - R8 = {r5, r5[4:2]}
  - G8 = {g6, g6[5:4]}
  - B8 = {b5, b5[4:2]}
- Blanking: if the delayed `ad` is 0, `pixel_out` is forced to 24'h0 regardless of `data_in`.
- Swap handshake:
  - On a cycle with `nf_in=1` and `swap_req_in=1` (same-cycle counts), toggle `front_buf` and pulse `swap_ack_out` on the next cycle.
  - `swap_req_in` without `nf_in` does nothing. The request stays pending while held.
  - The writer drops `swap_req_in` after the ack. If it is still high at the next `nf_in`, a second swap occurs, which is defined behaviour.
  - `front_buf` only changes in vertical blanking, so there is no mid-frame tearing.
- Reset clears `front_buf=0`, `swap_ack_out=0`, `rd_en_out=0`, `addr_out=0`, `pixel_out=0`, `hs_out/vs_out/ad_out=0`, and all pipeline registers. Reset mid-frame discards in-flight reads; outputs stay 0 until the pipeline refills from the live inputs.

## Timing
- Total latency is L = BRAM_LATENCY + 2 cycles, input strobe to `pixel_out`/`hs_out`/`vs_out`/`ad_out`. Default L = 4.
- hs/vs/ad pass through an L-deep shift register. Their edges leave exactly L cycles after they enter.
- `rd_en_out` asserts 1 cycle after `ad_in` rises. `data_in` is sampled `BRAM_LATENCY` cycles after that, and `pixel_out` registers 1 cycle later.
- `front_buf_out` changes 1 cycle after the qualifying `nf_in`, in the same cycle as `swap_ack_out`.
- `front_buf` is sampled in S0 only, so reads in flight at the swap cannot be affected. No active reads exist during `nf_in` anyway.
- The swap is the only multi-cycle handshake. There is no backpressure: the BRAM must accept one read per cycle.

## Structure
- Shared package `video_pkg`:
  - `FB_W` and `FB_H` derivation as localparam functions
  - `rgb565_t` / `rgb888_t` typedefs
  - `function rgb565_to_888`, reused by the debug overlay
- One sub-module, `strobe_delay #(WIDTH, DEPTH)`: a generic synchronous-reset shift register, used for {hs, vs, ad}.
- Address generation, swap logic and expansion live in the top module.

## Test plan
- Reset held for 3 cycles with random inputs. Required: every output is 0 and `front_buf_out=0`.
- Full frame driven by `video_sig_gen`, BRAM model returning `data = addr[15:0]`. Required: hcount 0–3 on line 0 all read addr 0, hcount 4 reads addr 1, vcount 4/hcount 0 reads addr 320. `pixel_out` lags `ad_out`-aligned input by exactly 4 cycles.
- `data_in = 16'hF800` during active video. Required: `pixel_out = 24'hFF0000`. `16'h07E0` gives 24'h00FF00. In blanking, `pixel_out = 0`.
- `swap_req_in` asserted mid-frame at line 100. Required: no ack until `nf_in`. The next cycle gives `swap_ack_out=1` for 1 cycle and `front_buf_out=1`. Line 0 of the next frame reads addr 57600.
- `swap_req_in` rising in the same cycle as `nf_in`. Required: the swap happens. With req held across two frames, two toggles occur and `front_buf_out` returns to 0.
- `rst_in` pulsed at line 300, pixel 500. Required: outputs are 0 the next cycle, `front_buf_out=0`, and correct alignment resumes L cycles after the counts resume.
